// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter feeding a shared two-stage 8-bit shift/rotate pipeline with a tagged response port.
// Optional feature: define BSHIFT_ARB_STATS_EN to build the saturating ops_count counter.
module barrel_shift_arbiter #(
    parameter int DATA_W = 8,
    parameter int NREQ   = 4,
    parameter int IDW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*3-1:0]      req_amt,
    input  logic [NREQ*2-1:0]      req_mode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic [15:0]            ops_count
);

    logic [IDW-1:0]    last_q;
    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [2:0]        s1_amt_q;
    logic [1:0]        s1_mode_q;
    logic [IDW-1:0]    s1_id_q;
    logic              s2_vld_q;
    logic [DATA_W-1:0] s2_data_q;
    logic [IDW-1:0]    s2_id_q;

    logic              s2_load;
    logic              s1_accept;
    logic              gnt_any;
    logic [IDW-1:0]    gnt_idx;
    logic [NREQ-1:0]   gnt_oh;
    logic [IDW-1:0]    cand;
    logic [DATA_W-1:0] s1_data_d;
    logic [2:0]        s1_amt_d;
    logic [1:0]        s1_mode_d;
    logic [DATA_W-1:0] s2_data_d;

    function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] d,
                                                   input logic [2:0] amt,
                                                   input logic [1:0] mode);
        logic signed [DATA_W-1:0] sd;
        logic [2*DATA_W-1:0]      rot;
        logic [DATA_W-1:0]        res;
        sd  = d;
        rot = {d, d} << amt;
        case (mode)
            2'b00:   res = d << amt;
            2'b01:   res = d >> amt;
            2'b10:   res = rot[2*DATA_W-1:DATA_W];
            default: res = sd >>> amt;
        endcase
        return res;
    endfunction

    assign s2_load   = !s2_vld_q || rsp_ready;
    assign s1_accept = !s1_vld_q || s2_load;

    // Search begins one past the last winner; first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any      = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        s1_data_d = '0;
        s1_amt_d  = '0;
        s1_mode_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                s1_data_d = req_data[i*DATA_W +: DATA_W];
                s1_amt_d  = req_amt[i*3 +: 3];
                s1_mode_d = req_mode[i*2 +: 2];
            end
        end
    end

    assign req_ready = (s1_accept && rst_n) ? gnt_oh : '0;
    assign s2_data_d = shift_op(s1_data_q, s1_amt_q, s1_mode_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= IDW'(NREQ - 1);
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_amt_q  <= '0;
            s1_mode_q <= '0;
            s1_id_q   <= '0;
        end else if (s1_accept) begin
            // Stage 1: operand capture from the granted requester
            s1_vld_q <= gnt_any;
            if (gnt_any) begin
                last_q    <= gnt_idx;
                s1_data_q <= s1_data_d;
                s1_amt_q  <= s1_amt_d;
                s1_mode_q <= s1_mode_d;
                s1_id_q   <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
        end else if (s2_load) begin
            // Stage 2: shift result register, held while the response is stalled
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_data_q <= s2_data_d;
                s2_id_q   <= s1_id_q;
            end
        end
    end

    assign rsp_valid = s2_vld_q;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;

`ifdef BSHIFT_ARB_STATS_EN
    logic [15:0] ops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q <= '0;
        end else if (s2_vld_q && rsp_ready && ops_q != 16'hFFFF) begin
            ops_q <= ops_q + 16'd1;
        end
    end

    assign ops_count = ops_q;
`else
    assign ops_count = 16'h0000;
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Randomized scoreboard bench for barrel_shift_arbiter with a behavioural round-robin/shift model.
module tb_barrel_shift_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_data = '0;
    logic [NREQ*3-1:0]   req_amt = '0;
    logic [NREQ*2-1:0]   req_mode = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [7:0]          rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         ops_count;

    barrel_shift_arbiter #(.DATA_W(8), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .ops_count(ops_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         id;
        int         stamp;
    } exp_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [12:0] pend[NREQ][$];
    exp_t        sb[$];
    int          cyc = 0;
    int          last_g = NREQ - 1;
    int          cnt_m = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Plain-arithmetic model of the four shift modes
    function automatic logic [7:0] ref_shift(input int d, input int a, input int m);
        int p, r, v, q;
        p = 1 << a;
        case (m)
            0: r = (d * p) % 256;
            1: r = d / p;
            2: r = (d * p) % 256 + d / (256 / p);
            default: begin
                v = (d >= 128) ? d - 256 : d;
                q = (v >= 0) ? v / p : -((-v + p - 1) / p);
                r = (q + 256) % 256;
            end
        endcase
        return 8'(r);
    endfunction

    // Requester driver: presents the head of each requester's queue until it transfers
    initial begin
        logic [NREQ-1:0] xf;
        forever begin
            @(negedge clk);
            xf = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (xf[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                if (pend[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = pend[i][0][7:0];
                    req_amt[i*3 +: 3]   = pend[i][0][10:8];
                    req_mode[i*2 +: 2]  = pend[i][0][12:11];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*8 +: 8]  = '0;
                    req_amt[i*3 +: 3]   = '0;
                    req_mode[i*2 +: 2]  = '0;
                end
            end
        end
    end

    // Monitor: arbitration model, latency/order scoreboard, stall stability, op counter
    initial begin
        logic        hold;
        logic [7:0]  hold_data;
        logic [1:0]  hold_id;
        int          pre, w, c, expv_ops;
        logic        exp_v, acc;
        logic [NREQ-1:0] exp_rdy;
        hold = 1'b0; hold_data = '0; hold_id = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                last_g = NREQ - 1;
                cnt_m  = 0;
                hold   = 1'b0;
            end else begin
                cyc++;
`ifdef BSHIFT_ARB_STATS_EN
                expv_ops = cnt_m;
`else
                expv_ops = 0;
`endif
                check("ops_count", 32'(ops_count), 32'(expv_ops));
                pre   = sb.size();
                exp_v = (sb.size() > 0) && (cyc - sb[0].stamp >= 2);
                check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
                if (hold) begin
                    check("stall_data", 32'(rsp_data), 32'(hold_data));
                    check("stall_id", 32'(rsp_id), 32'(hold_id));
                end
                if (rsp_valid && sb.size() > 0) begin
                    check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                    check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        if (cnt_m < 65535) cnt_m++;
                    end
                end
                hold      = rsp_valid && !rsp_ready;
                hold_data = rsp_data;
                hold_id   = rsp_id;
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (last_g + k) % NREQ;
                    if (w < 0 && req_valid[c]) w = c;
                end
                acc     = (pre < 2) || rsp_ready;
                exp_rdy = (acc && w >= 0) ? NREQ'(1 << w) : '0;
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (exp_rdy != 0) begin
                    sb.push_back('{data: ref_shift(int'(req_data[w*8 +: 8]), int'(req_amt[w*3 +: 3]),
                                                   int'(req_mode[w*2 +: 2])),
                                   id: w, stamp: cyc});
                    last_g = w;
                end
            end
        end
    end

    function automatic logic [12:0] rnd_op();
        return 13'($urandom);
    endfunction

    task automatic drain(input string nm);
        logic done;
        int   busy;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(posedge clk);
            #2;
            busy = sb.size();
            for (int i = 0; i < NREQ; i++) busy += pend[i].size();
            if (busy == 0 && !rsp_valid) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_%s: got pipeline busy expected empty", nm);
        end
    endtask

    initial begin
        logic ok;
        // Request held through reset; requester 0 must still see nothing until release
        pend[0].push_back({2'b01, 3'd4, 8'h80});
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_ops_count", 32'(ops_count), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drain("single");

        for (int m = 0; m < 4; m++) begin
            pend[0].push_back({2'(m), 3'd3, 8'hB1});
            pend[1].push_back({2'(m), 3'd0, 8'hB1});
        end
        drain("modes");

        for (int r = 0; r < NREQ; r++)
            for (int j = 0; j < 8; j++) pend[r].push_back(rnd_op());
        drain("fair");

        @(posedge clk);
        #2 rsp_ready = 1'b0;
        for (int r = 1; r < NREQ; r++) pend[r].push_back(rnd_op());
        repeat (5) @(posedge clk);
        #2;
        check("bp_req_ready", 32'(req_ready), 32'h0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        drain("bp");

        repeat (400) begin
            @(posedge clk);
            #2;
            rsp_ready = ($urandom % 4) != 0;
            if ($urandom % 2 == 1) begin
                int r;
                r = int'($urandom % NREQ);
                if (pend[r].size() < 3) pend[r].push_back(rnd_op());
            end
        end
        rsp_ready = 1'b1;
        drain("random");

        @(posedge clk);
        #2 rsp_ready = 1'b0;
        for (int r = 0; r < NREQ; r++) pend[r].push_back(rnd_op());
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(posedge clk);
            #2;
            if (rsp_valid && sb.size() == 2) ok = 1'b1;
        end
        check("mid_fill", 32'(ok), 32'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_req_ready", 32'(req_ready), 32'h0);
        check("mid_rsp_data", 32'(rsp_data), 32'h0);
        check("mid_ops_count", 32'(ops_count), 32'h0);
        pend[0].push_back(rnd_op());
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Shares one 8-bit barrel-shift datapath among NREQ requesters. A round-robin arbiter grants one request per cycle into a two-stage pipeline: operand capture, then shift/rotate. Each result returns on a single tagged response port with valid/ready backpressure. The block sits between the ALU-side issue logic and the shifter, replacing per-requester shifter instances.

## Interface
- DATA_W, 8, operand/result width (fixed at 8; shift amount is 3 bits)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester tag width, clog2(NREQ)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_data  input  NREQ*8  operand, requester i in bits [8i+7:8i]
- req_amt  input  NREQ*3  shift amount, requester i in bits [3i+2:3i]
- req_mode  input  NREQ*2  00 logical left, 01 logical right, 10 rotate left, 11 arithmetic right
- rsp_valid  output  1  result valid
- rsp_ready  input  1  downstream accepts result
- rsp_data  output  8  shifted result
- rsp_id  output  IDW  index of requester that issued the operation
- ops_count  output  16  completed-operation counter (see Configuration)

## Operation
- Transfer on a port occurs when valid && ready are both high at a rising clk.
- Arbitration: round-robin over req_valid. Search starts at (last_grant+1) mod NREQ. last_grant resets to NREQ-1, so requester 0 has first priority after reset. last_grant updates only on an actual transfer.
- req_ready[i] is high only for the winner, and only when stage 1 can accept. It may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready. Once asserted, a request holds valid and its fields until transferred.
- Stage 1 (S1) registers the operand, amount, mode and id. Stage 2 (S2) registers the shift result, id and valid.
- Shift rules:
  - Left shift fills zeros.
  - Logical right shift fills zeros.
  - Arithmetic right shift replicates bit 7.
  - Rotate left wraps bits. Amount 0 passes data unchanged in every mode.
- Flow control:
  - S2 loads when it is empty or rsp_ready is high.
  - S1 advances into S2 under the same condition.
  - S1 accepts a new grant when it is empty or advancing.
  - Full throughput is 1 op/cycle with no bubbles while rsp_ready stays high.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_id and rsp_valid hold stable. S1 holds its contents. If S1 is full, all req_ready are low.
- Reset, including mid-operation, clears in-flight operations without emitting them:
  - S1 and S2 valid flags go to 0, and last_grant goes to NREQ-1.
  - ops_count goes to 0.
  - rsp_valid, rsp_data, rsp_id and req_ready are all 0.

## Timing
- Latency is 2 cycles: a request transferred at edge N gives rsp_valid high after edge N+1 and before edge N+2, i.e. it is presented for the cycle following edge N+1.
- Arbitration and the shift are combinational within their stage. There is one register per stage.
- Simultaneous events resolve in a single cycle: a response transfer and a new request grant in the same cycle both complete.
- ops_count increments on each response transfer and saturates at 16'hFFFF.

## Configuration
- BSHIFT_ARB_STATS_EN
  - Defined: ops_count is a live 16-bit saturating counter of response transfers. It clears on reset.
  - Undefined: ops_count is tied to 16'h0000 and no counter register is built.

## Test plan
- Single request: reset, then req 0 with data 8'h80, amt 4, mode 01 → rsp_data 8'h08, rsp_id 0, two cycles after the transfer.
- Modes on data 8'hB1, amt 3:
  - mode 00 → 8'h88
  - mode 01 → 8'h16
  - mode 10 → 8'h8D
  - mode 11 → 8'hF6
  - amt 0 → 8'hB1 in all modes.
- Fairness: all 4 requesters hold valid continuously with rsp_ready=1 → grant order 0,1,2,3,0,1…, one response per cycle and no bubbles.
- Backpressure: rsp_ready low for 5 cycles with 3 requests pending → exactly 2 ops in flight, req_ready all 0, rsp_data stable. On release, responses drain in grant order and none are lost or duplicated.
- Reset mid-operation: assert rst_n low while S1 and S2 are full → rsp_valid drops immediately. After release, no stale response appears, and requester 0 has priority again.
- Stats with BSHIFT_ARB_STATS_EN defined: 10 responses → ops_count 10. Undefined → ops_count stays 0.
